// File: rtl/tick_period_monitor_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tick_mon_pkg
// Brief  : Shared types and default constants for tick_period_monitor.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package tick_mon_pkg;

  // Monitor state: waiting for first tick, acquiring good gaps, locked
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } tm_state_t;

  localparam int DEF_PERIOD = 5001;
  localparam int DEF_TOL    = 2;
  localparam int DEF_CBITS  = 14;
  localparam int DEF_LOCK_N = 3;
  localparam int DEF_EVBITS = 8;

  // Width of the good-gap run counter; must be able to hold LOCK_N
  function automatic int run_bits(input int lock_n);
    return (lock_n < 1) ? 1 : $clog2(lock_n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_period_monitor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tick_mon_if
// Brief  : Tick input / status output bundle of the tick period monitor.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface tick_mon_if #(
  parameter int EVBITS = 8
);
  logic              en;
  logic              tick;
  logic              locked;
  logic              early_err;
  logic              miss_err;
  logic [EVBITS-1:0] tick_cnt;
  logic [EVBITS-1:0] err_cnt;

  // Upstream side: drives enable and tick, observes status
  modport master (
    output en, tick,
    input  locked, early_err, miss_err, tick_cnt, err_cnt
  );

  // Monitor side
  modport slave (
    input  en, tick,
    output locked, early_err, miss_err, tick_cnt, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/tick_period_monitor_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sat_counter
// Brief  : Up counter that sticks at all-ones; synchronous clear via rst.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         inc,
  output logic [W-1:0]      q
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Increment unless already at the maximum value
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;
endmodule
`default_nettype wire

// File: rtl/tick_period_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tick_period_monitor
// Brief  : Measures gaps between periodic ticks, locks after LOCK_N good
//          gaps, flags early and missing ticks, counts ticks and errors.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tick_period_monitor
  import tick_mon_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD,
  parameter int TOL    = DEF_TOL,
  parameter int CBITS  = DEF_CBITS,
  parameter int LOCK_N = DEF_LOCK_N,
  parameter int EVBITS = DEF_EVBITS
) (
  input  wire logic   clk,
  input  wire logic   rst,
  tick_mon_if.slave   bus
);
  localparam int               RBITS    = run_bits(LOCK_N);
  localparam logic [CBITS-1:0] GAP_LO   = CBITS'(PERIOD - TOL);
  localparam logic [CBITS-1:0] GAP_HI   = CBITS'(PERIOD + TOL);
  localparam logic [CBITS-1:0] GAP_ONE  = CBITS'(1);
  localparam logic [RBITS-1:0] RUN_MAX  = RBITS'(LOCK_N);
  localparam logic [RBITS-1:0] RUN_LAST = RBITS'(LOCK_N - 1);

  if ((PERIOD - TOL) < 1 || (PERIOD + TOL) >= (2 ** CBITS) || LOCK_N < 1) begin : g_param_check
    $error("tick_period_monitor: PERIOD/TOL/CBITS/LOCK_N out of range");
  end

  tm_state_t         state_q, state_d;
  logic [CBITS-1:0]  gap_q, gap_d;
  logic              locked_q, locked_d;
  logic              early_q, early_d;
  logic              miss_q, miss_d;
  logic [EVBITS-1:0] tick_cnt_q, tick_cnt_d;
  logic [RBITS-1:0]  run;
  logic              run_clr;
  logic              run_inc;
  logic [EVBITS-1:0] err_cnt;

  // Next-state, gap counter, run control and error decisions
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    early_d    = 1'b0;
    miss_d     = 1'b0;
    run_clr    = 1'b0;
    run_inc    = 1'b0;
    tick_cnt_d = tick_cnt_q;

    if (bus.en && bus.tick) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    if (!bus.en) begin
      state_d = ST_IDLE;
      gap_d   = '0;
      run_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          gap_d   = '0;
          run_clr = 1'b1;
          if (bus.tick) begin
            state_d = ST_ACQ;
            gap_d   = GAP_ONE;
          end
        end
        ST_ACQ, ST_LOCK: begin
          if (bus.tick) begin
            // Every tick restarts the gap measurement
            gap_d = GAP_ONE;
            if (gap_q < GAP_LO) begin
              early_d = 1'b1;
              run_clr = 1'b1;
              state_d = ST_ACQ;
            end else begin
              run_inc = (run != RUN_MAX);
              if (state_q == ST_ACQ && run == RUN_LAST) begin
                state_d = ST_LOCK;
              end
            end
          end else if (gap_q >= GAP_HI) begin
            miss_d  = 1'b1;
            state_d = ST_IDLE;
            gap_d   = '0;
            run_clr = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          gap_d   = '0;
          run_clr = 1'b1;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCK);
  end

  // State, gap, tick count and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      locked_q   <= 1'b0;
      early_q    <= 1'b0;
      miss_q     <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      locked_q   <= locked_d;
      early_q    <= early_d;
      miss_q     <= miss_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  sat_counter #(.W(RBITS)) u_run_cnt (
    .clk (clk),
    .rst (rst | run_clr),
    .inc (run_inc),
    .q   (run)
  );

  sat_counter #(.W(EVBITS)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (early_d | miss_d),
    .q   (err_cnt)
  );

  assign bus.locked    = locked_q;
  assign bus.early_err = early_q;
  assign bus.miss_err  = miss_q;
  assign bus.tick_cnt  = tick_cnt_q;
  assign bus.err_cnt   = err_cnt;
endmodule
`default_nettype wire

// File: tb/tb_tick_period_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_tick_period_monitor
// Brief  : Directed self-checking bench for tick_period_monitor
//          (PERIOD=10, TOL=1, LOCK_N=3, EVBITS=8).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_tick_period_monitor;
  localparam int PERIOD = 10;
  localparam int TOL    = 1;
  localparam int CBITS  = 6;
  localparam int LOCK_N = 3;
  localparam int EVBITS = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  tick_mon_if #(.EVBITS(EVBITS)) bus ();

  tick_period_monitor #(
    .PERIOD (PERIOD),
    .TOL    (TOL),
    .CBITS  (CBITS),
    .LOCK_N (LOCK_N),
    .EVBITS (EVBITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // The two error pulses must never coincide
  always @(negedge clk) begin
    checks++;
    if ((bus.early_err & bus.miss_err) === 1'b1) begin
      errors++;
      $display("FAIL both_errors: early_err=%0b miss_err=%0b required not both 1",
               bus.early_err, bus.miss_err);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle tick; on return the outputs show the decision for that tick
  task automatic pulse();
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
  endtask

  // Tick arriving with gap g, starting from the cycle just after a tick
  task automatic tick_after(input int g);
    cycles(g - 1);
    pulse();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.tick = 1'b0;
    cycles(2);
    rst = 1'b0;
    checks++;
    if ({bus.locked, bus.early_err, bus.miss_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000", {bus.locked, bus.early_err, bus.miss_err});
    end
    checks++;
    if (bus.tick_cnt !== 8'd0 || bus.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: tick_cnt=%0d err_cnt=%0d required 0/0", bus.tick_cnt, bus.err_cnt);
    end
  endtask

  task automatic test_lock();
    bus.en = 1'b1;
    cycles(1);
    pulse();
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_first_tick: locked=%b required 0", bus.locked);
    end
    for (int i = 0; i < 3; i++) begin
      tick_after(10);
      checks++;
      if (bus.locked !== (i == 2)) begin
        errors++;
        $display("FAIL lock_gap%0d: locked=%b required %b", i, bus.locked, (i == 2));
      end
    end
    checks++;
    if (bus.tick_cnt !== 8'd4 || bus.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL lock_counts: tick_cnt=%0d err_cnt=%0d required 4/0", bus.tick_cnt, bus.err_cnt);
    end
  endtask

  task automatic test_tolerance();
    tick_after(9);
    checks++;
    if (bus.locked !== 1'b1 || bus.early_err !== 1'b0) begin
      errors++;
      $display("FAIL tol_gap9: locked=%b early=%b required 1/0", bus.locked, bus.early_err);
    end
    tick_after(11);
    checks++;
    if (bus.locked !== 1'b1 || bus.early_err !== 1'b0 || bus.miss_err !== 1'b0) begin
      errors++;
      $display("FAIL tol_gap11: locked=%b early=%b miss=%b required 1/0/0",
               bus.locked, bus.early_err, bus.miss_err);
    end
    checks++;
    if (bus.tick_cnt !== 8'd6) begin
      errors++;
      $display("FAIL tol_tick_cnt: got %0d required 6", bus.tick_cnt);
    end
  endtask

  task automatic test_early();
    tick_after(7);
    checks++;
    if (bus.early_err !== 1'b1 || bus.locked !== 1'b0 || bus.err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL early_pulse: early=%b locked=%b err_cnt=%0d required 1/0/1",
               bus.early_err, bus.locked, bus.err_cnt);
    end
    cycles(1);
    checks++;
    if (bus.early_err !== 1'b0) begin
      errors++;
      $display("FAIL early_width: early=%b required 0", bus.early_err);
    end
    // Gap is 2 here; complete a gap of 10 from the early tick
    cycles(8);
    pulse();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.locked !== 1'b0) begin
        errors++;
        $display("FAIL relock_wait%0d: locked=%b required 0", i, bus.locked);
      end
      tick_after(10);
    end
    checks++;
    if (bus.locked !== 1'b1 || bus.tick_cnt !== 8'd10) begin
      errors++;
      $display("FAIL relock: locked=%b tick_cnt=%0d required 1/10", bus.locked, bus.tick_cnt);
    end
  endtask

  task automatic test_miss();
    cycles(10);
    checks++;
    if (bus.miss_err !== 1'b0 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL miss_at_gap11: miss=%b locked=%b required 0/1", bus.miss_err, bus.locked);
    end
    cycles(1);
    checks++;
    if (bus.miss_err !== 1'b1 || bus.locked !== 1'b0 || bus.err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL miss_pulse: miss=%b locked=%b err_cnt=%0d required 1/0/2",
               bus.miss_err, bus.locked, bus.err_cnt);
    end
    cycles(1);
    checks++;
    if (bus.miss_err !== 1'b0) begin
      errors++;
      $display("FAIL miss_width: miss=%b required 0", bus.miss_err);
    end
    cycles(20);
    checks++;
    if (bus.miss_err !== 1'b0 || bus.err_cnt !== 8'd2 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL miss_idle: miss=%b err_cnt=%0d locked=%b required 0/2/0",
               bus.miss_err, bus.err_cnt, bus.locked);
    end
    pulse();
    for (int i = 0; i < 3; i++) tick_after(10);
    checks++;
    if (bus.locked !== 1'b1 || bus.tick_cnt !== 8'd14 || bus.err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL miss_reacquire: locked=%b tick_cnt=%0d err_cnt=%0d required 1/14/2",
               bus.locked, bus.tick_cnt, bus.err_cnt);
    end
  endtask

  task automatic test_enable();
    bus.en = 1'b0;
    pulse();
    checks++;
    if (bus.locked !== 1'b0 || bus.tick_cnt !== 8'd14) begin
      errors++;
      $display("FAIL en_low: locked=%b tick_cnt=%0d required 0/14", bus.locked, bus.tick_cnt);
    end
    bus.en = 1'b1;
    pulse();
    checks++;
    if (bus.early_err !== 1'b0 || bus.tick_cnt !== 8'd15 || bus.err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL en_restart: early=%b tick_cnt=%0d err_cnt=%0d required 0/15/2",
               bus.early_err, bus.tick_cnt, bus.err_cnt);
    end
    for (int i = 0; i < 22; i++) tick_after(10);
    checks++;
    if (bus.locked !== 1'b1 || bus.tick_cnt !== 8'd37) begin
      errors++;
      $display("FAIL en_lock37: locked=%b tick_cnt=%0d required 1/37", bus.locked, bus.tick_cnt);
    end
  endtask

  task automatic test_reset_priority();
    cycles(9);
    rst      = 1'b1;
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.tick = 1'b0;
    checks++;
    if ({bus.locked, bus.early_err, bus.miss_err} !== 3'b000 ||
        bus.tick_cnt !== 8'd0 || bus.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_priority: flags=%b tick_cnt=%0d err_cnt=%0d required 000/0/0",
               {bus.locked, bus.early_err, bus.miss_err}, bus.tick_cnt, bus.err_cnt);
    end
    cycles(1);
    checks++;
    if (bus.tick_cnt !== 8'd0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL rst_tick_dropped: tick_cnt=%0d locked=%b required 0/0", bus.tick_cnt, bus.locked);
    end
  endtask

  task automatic test_back_to_back();
    bus.tick = 1'b1;
    cycles(300);
    bus.tick = 1'b0;
    checks++;
    if (bus.early_err !== 1'b1 || bus.err_cnt !== 8'd255 || bus.tick_cnt !== 8'd44) begin
      errors++;
      $display("FAIL b2b_saturate: early=%b err_cnt=%0d tick_cnt=%0d required 1/255/44",
               bus.early_err, bus.err_cnt, bus.tick_cnt);
    end
    cycles(14);
    checks++;
    if (bus.err_cnt !== 8'd255 || bus.tick_cnt !== 8'd44 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: err_cnt=%0d tick_cnt=%0d locked=%b required 255/44/0",
               bus.err_cnt, bus.tick_cnt, bus.locked);
    end
  endtask

  initial begin
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.tick = 1'b0;
    test_reset();
    test_lock();
    test_tolerance();
    test_early();
    test_miss();
    test_enable();
    test_reset_priority();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
